// File: rtl/sgpr_ckpt_ctrl.sv
// Checkpoint/restore sequencer for the primary/shadow sgpr pair.
// Copies R1..R(N-1) between files through a one-deep read->write pipeline while busy_o stalls the core.
module sgpr_ckpt_ctrl #(
    parameter bit RV32E      = 1'b0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ckpt_req_i,
    input  logic                  restore_req_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  dir_o,
    output logic                  req_drop_o,
    output logic [4:0]            prim_raddr_o,
    input  logic [DATA_WIDTH-1:0] prim_rdata_i,
    output logic [4:0]            shad_raddr_o,
    input  logic [DATA_WIDTH-1:0] shad_rdata_i,
    output logic [4:0]            prim_waddr_o,
    output logic [DATA_WIDTH-1:0] prim_wdata_o,
    output logic                  prim_we_o,
    output logic [4:0]            shad_waddr_o,
    output logic [DATA_WIDTH-1:0] shad_wdata_o,
    output logic                  shad_we_o
);

    localparam int ADDR_WIDTH = RV32E ? 4 : 5;
    localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    dir_q, dir_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    drop_q, drop_d;
    logic [4:0]              prim_raddr_q, prim_raddr_d;
    logic [4:0]              shad_raddr_q, shad_raddr_d;
    logic [4:0]              prim_waddr_q, prim_waddr_d;
    logic [4:0]              shad_waddr_q, shad_waddr_d;
    logic [DATA_WIDTH-1:0]   prim_wdata_q, prim_wdata_d;
    logic [DATA_WIDTH-1:0]   shad_wdata_q, shad_wdata_d;
    logic                    prim_we_q, prim_we_d;
    logic                    shad_we_q, shad_we_d;
    logic                    req_any;

    assign req_any = ckpt_req_i | restore_req_i;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dir_d        = dir_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        drop_d       = 1'b0;
        prim_raddr_d = '0;
        shad_raddr_d = '0;
        prim_waddr_d = '0;
        shad_waddr_d = '0;
        prim_wdata_d = '0;
        shad_wdata_d = '0;
        prim_we_d    = 1'b0;
        shad_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = COPY;
                    dir_d   = restore_req_i;
                    idx_d   = ONE_IDX;
                    busy_d  = 1'b1;
                    if (restore_req_i) shad_raddr_d = 5'(ONE_IDX);
                    else               prim_raddr_d = 5'(ONE_IDX);
                end
            end
            COPY: begin
                drop_d = req_any;
                busy_d = 1'b1;
                // Registered write of the word read this cycle lands on the destination next cycle.
                if (dir_q) begin
                    prim_we_d    = 1'b1;
                    prim_waddr_d = 5'(idx_q);
                    prim_wdata_d = shad_rdata_i;
                end else begin
                    shad_we_d    = 1'b1;
                    shad_waddr_d = 5'(idx_q);
                    shad_wdata_d = prim_rdata_i;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + ONE_IDX;
                    if (dir_q) shad_raddr_d = 5'(idx_q + ONE_IDX);
                    else       prim_raddr_d = 5'(idx_q + ONE_IDX);
                end
            end
            DRAIN: begin
                drop_d  = req_any;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                drop_d  = req_any;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            prim_raddr_q <= '0;
            shad_raddr_q <= '0;
            prim_waddr_q <= '0;
            shad_waddr_q <= '0;
            prim_wdata_q <= '0;
            shad_wdata_q <= '0;
            prim_we_q    <= 1'b0;
            shad_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            prim_raddr_q <= prim_raddr_d;
            shad_raddr_q <= shad_raddr_d;
            prim_waddr_q <= prim_waddr_d;
            shad_waddr_q <= shad_waddr_d;
            prim_wdata_q <= prim_wdata_d;
            shad_wdata_q <= shad_wdata_d;
            prim_we_q    <= prim_we_d;
            shad_we_q    <= shad_we_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign dir_o        = dir_q;
    assign req_drop_o   = drop_q;
    assign prim_raddr_o = prim_raddr_q;
    assign shad_raddr_o = shad_raddr_q;
    assign prim_waddr_o = prim_waddr_q;
    assign shad_waddr_o = shad_waddr_q;
    assign prim_wdata_o = prim_wdata_q;
    assign shad_wdata_o = shad_wdata_q;
    assign prim_we_o    = prim_we_q;
    assign shad_we_o    = shad_we_q;

endmodule

// File: doc/sgpr_ckpt_ctrl.md
Name: sgpr_ckpt_ctrl

Overview:
Checkpoint/restore sequencer for the fault-tolerant register file pair (primary sgpr + shadow sgpr).
- On a checkpoint request it walks the primary file's read port and copies R1..R(N-1) into the shadow file's write port.
- On a restore (replay) request it copies shadow -> primary.
- It stalls the core while copying. Sits beside the two sgpr instances; the external write-port mux is steered by busy_o.

Parameters:
- RV32E, 0, 1 selects 16-entry file (ADDR_WIDTH=4), 0 selects 32-entry (ADDR_WIDTH=5); NUM_WORDS=2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width in bits.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- ckpt_req_i  in  1  start checkpoint (primary -> shadow); sampled only in IDLE.
- restore_req_i  in  1  start restore/replay (shadow -> primary); sampled only in IDLE.
- busy_o  out  1  copy in progress; core must stall; steers sgpr write-port muxes.
- done_o  out  1  one-cycle pulse when a copy completes.
- dir_o  out  1  0 = checkpoint, 1 = restore; valid while busy_o.
- req_drop_o  out  1  one-cycle pulse when a request arrives while not IDLE.
- prim_raddr_o  out  5  primary read address.
- prim_rdata_i  in  DATA_WIDTH  primary read data (combinational from sgpr).
- shad_raddr_o  out  5  shadow read address.
- shad_rdata_i  in  DATA_WIDTH  shadow read data (combinational).
- prim_waddr_o  out  5  primary write address.
- prim_wdata_o  out  DATA_WIDTH  primary write data.
- prim_we_o  out  1  primary write enable.
- shad_waddr_o  out  5  shadow write address.
- shad_wdata_o  out  DATA_WIDTH  shadow write data.
- shad_we_o  out  1  shadow write enable.

Behaviour:
- Reset values (rst high at a clk edge): state IDLE.
  - busy_o, done_o, req_drop_o, dir_o, prim_we_o and shad_we_o are all 0.
  - All addresses and wdata are 0.
- FSM states: IDLE, COPY, DRAIN, DONE.
- IDLE:
  - If restore_req_i, go to COPY with dir=1.
  - Else if ckpt_req_i, go to COPY with dir=0.
  - Restore has priority when both requests are high; the lost checkpoint is not flagged.
- Read stage (COPY):
  - Index counter idx starts at 1.
  - Each cycle, drive idx on the source file's read address. The source file is primary if dir=0, shadow if dir=1.
  - Capture the source rdata and idx into a 1-deep pipeline register.
  - idx increments each cycle. When idx == NUM_WORDS-1, go to DRAIN.
  - R0 is never read or written.
- Write stage:
  - One cycle after each read, drive the captured address/data on the destination file's write port with we=1.
  - The other file's we stays 0 at all times.
- DRAIN: performs the final write only (R(NUM_WORDS-1)); no read. Next state DONE.
- DONE:
  - done_o=1 and busy_o=0 for this one cycle.
  - Then IDLE. A request in this cycle is sampled as IDLE's next cycle, i.e. it is dropped.
- busy_o:
  - High in COPY and DRAIN: exactly NUM_WORDS cycles (32 for RV32E=0, 16 for RV32E=1).
  - Latency from request edge to done_o is NUM_WORDS+1 cycles.
- Unused read addresses are driven to 0.
- req_drop_o pulses for one cycle if ckpt_req_i or restore_req_i is high in COPY, DRAIN or DONE. The request has no other effect.
- Address outputs are 5 bits wide; upper bit is 0 when RV32E=1.
- Reset mid-operation:
  - Next cycle, all we=0, busy_o=0, state IDLE.
  - A partial copy is left as-is; no done_o pulse.
- Data is copied bit-exact; no transformation.

Test Plan:
- Preload primary Rk=0xA5A50000+k; pulse ckpt_req_i -> busy_o high 32 cycles, shad_we_o writes addr 1..31 in order with matching data, prim_we_o never 1, done_o pulses on cycle 33.
- Preload shadow Rk=0x5A5A0000+k; pulse restore_req_i -> primary R1..R31 equal shadow, shad_we_o never 1, dir_o=1 throughout, R0 reads 0.
- Assert ckpt_req_i and restore_req_i in the same cycle -> restore performed (dir_o=1), no req_drop_o.
- Pulse ckpt_req_i at cycles 5 and 20 after start -> req_drop_o pulses at each, single copy of 32 busy cycles, one done_o.
- Assert rst at cycle 10 of a checkpoint -> next cycle busy_o=0, we=0; shadow R1..R9 updated, R10..R31 unchanged; no done_o.
- RV32E=1: ckpt_req_i -> writes addr 1..15, busy_o 16 cycles, done_o on cycle 17, address bit 4 always 0.
